// File: rtl/sarray_top.sv
// sarray_top: tensor-instruction execution block for a 4x4 int8 matrix engine.
// It executes one instruction at a time: PRELOADC, PRELOADA, TMMA or POSTSTOREC.
// It holds a stationary A tile, a staged B tile and a 4x4 32-bit C accumulator.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   issue_tinst_*                      instruction handshake and fields (latched on accept)
//   sarray_ar_* / sarray_r_*           read request and read data (one read outstanding at most)
//   sarray_aw_*                        combined write address+data channel
module sarray_top #(
    parameter int unsigned ADDR_WIDTH           = 32,
    parameter int unsigned TINST_TYPE_WIDTH     = 2,
    parameter int unsigned TMMA_PRECISION_WIDTH = 2,
    parameter int unsigned SARRAY_LOAD_WIDTH    = 128,
    parameter int unsigned SARRAY_STORE_WIDTH   = 128
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            issue_tinst_valid_i,
    output logic                            issue_tinst_ready_o,
    input  logic [TINST_TYPE_WIDTH-1:0]     issue_tinst_type_i,
    input  logic [ADDR_WIDTH-1:0]           issue_tinst_addr0_i,
    input  logic [ADDR_WIDTH-1:0]           issue_tinst_addr1_i,
    input  logic [TMMA_PRECISION_WIDTH-1:0] issue_tinst_precision_i,
    input  logic                            issue_tinst_acc_i,
    output logic                            sarray_ar_valid_o,
    input  logic                            sarray_ar_ready_i,
    output logic [ADDR_WIDTH-1:0]           sarray_ar_addr_o,
    input  logic                            sarray_r_valid_i,
    output logic                            sarray_r_ready_o,
    input  logic [SARRAY_LOAD_WIDTH-1:0]    sarray_r_data_i,
    output logic                            sarray_aw_valid_o,
    input  logic                            sarray_aw_ready_i,
    output logic [ADDR_WIDTH-1:0]           sarray_aw_addr_o,
    output logic [SARRAY_STORE_WIDTH-1:0]   sarray_aw_data_o
);

    localparam int unsigned TILE_W = 128;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned DIM    = 4;

    localparam logic [TINST_TYPE_WIDTH-1:0] TYPE_PRELOADC   = TINST_TYPE_WIDTH'(0);
    localparam logic [TINST_TYPE_WIDTH-1:0] TYPE_PRELOADA   = TINST_TYPE_WIDTH'(1);
    localparam logic [TINST_TYPE_WIDTH-1:0] TYPE_TMMA       = TINST_TYPE_WIDTH'(2);
    localparam logic [TINST_TYPE_WIDTH-1:0] TYPE_POSTSTOREC = TINST_TYPE_WIDTH'(3);
    localparam logic [TMMA_PRECISION_WIDTH-1:0] PREC_UNSIGNED = TMMA_PRECISION_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_COMPUTE,
        ST_WR_REQ
    } state_e;

    typedef logic [DIM-1:0][ACC_W-1:0] c_row_t;

    state_e                            state_q, state_d;
    logic [1:0]                        row_q, row_d;
    logic [TINST_TYPE_WIDTH-1:0]       type_q, type_d;
    logic [ADDR_WIDTH-1:0]             addr0_q, addr0_d;
    logic [ADDR_WIDTH-1:0]             addr1_q, addr1_d;
    logic [TMMA_PRECISION_WIDTH-1:0]   prec_q, prec_d;
    logic                              acc_q, acc_d;
    logic [TILE_W-1:0]                 a_q, a_d;
    logic [TILE_W-1:0]                 b_q, b_d;
    c_row_t [DIM-1:0]                  c_q, c_d;
    logic                              ready_q, ready_d;
    logic                              ar_valid_q, ar_valid_d;
    logic [ADDR_WIDTH-1:0]             ar_addr_q, ar_addr_d;
    logic                              r_ready_q, r_ready_d;
    logic                              aw_valid_q, aw_valid_d;
    logic [ADDR_WIDTH-1:0]             aw_addr_q, aw_addr_d;
    logic [SARRAY_STORE_WIDTH-1:0]     aw_data_q, aw_data_d;

    // addr1 is carried with the instruction but has no consumer yet
    logic unused_addr1_c;
    assign unused_addr1_c = ^addr1_q;

    // One row of A times B, added onto c_init; sums wrap modulo 2^32
    function automatic c_row_t mac_row(input logic [TILE_W-1:0] a_tile,
                                       input logic [TILE_W-1:0] b_tile,
                                       input logic [1:0]        row,
                                       input logic              uns,
                                       input c_row_t            c_init);
        c_row_t            res;
        logic signed [8:0]  ae;
        logic signed [8:0]  be;
        logic signed [17:0] prod;
        logic [7:0]         a_byte;
        logic [7:0]         b_byte;
        res = c_init;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 4; k++) begin
                a_byte = a_tile[32*int'(row) + 8*k +: 8];
                b_byte = b_tile[32*k + 8*j +: 8];
                ae     = uns ? $signed({1'b0, a_byte}) : $signed({a_byte[7], a_byte});
                be     = uns ? $signed({1'b0, b_byte}) : $signed({b_byte[7], b_byte});
                prod   = ae * be;
                res[j] = res[j] + {{14{prod[17]}}, prod};
            end
        end
        return res;
    endfunction

    // Address of row/beat r; wraps naturally at the address width
    function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [1:0]            r);
        return base + (ADDR_WIDTH'(r) << 4);
    endfunction

    // Next-state, datapath and output-register logic
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        type_d     = type_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        prec_d     = prec_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        r_ready_d  = r_ready_q;
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        aw_data_d  = aw_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (issue_tinst_valid_i) begin
                    type_d  = issue_tinst_type_i;
                    addr0_d = issue_tinst_addr0_i;
                    addr1_d = issue_tinst_addr1_i;
                    prec_d  = issue_tinst_precision_i;
                    acc_d   = issue_tinst_acc_i;
                    row_d   = 2'd0;
                    case (issue_tinst_type_i)
                        TYPE_PRELOADC, TYPE_PRELOADA, TYPE_TMMA: begin
                            state_d    = ST_RD_REQ;
                            ar_valid_d = 1'b1;
                            ar_addr_d  = issue_tinst_addr0_i;
                        end
                        TYPE_POSTSTOREC: begin
                            state_d    = ST_WR_REQ;
                            aw_valid_d = 1'b1;
                            aw_addr_d  = issue_tinst_addr0_i;
                            aw_data_d  = SARRAY_STORE_WIDTH'(c_q[0]);
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            ST_RD_REQ: begin
                if (sarray_ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (sarray_r_valid_i && r_ready_q) begin
                    r_ready_d = 1'b0;
                    state_d   = ST_IDLE;
                    case (type_q)
                        TYPE_PRELOADC: begin
                            c_d[row_q] = c_row_t'(TILE_W'(sarray_r_data_i));
                            if (row_q != 2'd3) begin
                                row_d      = row_q + 2'd1;
                                state_d    = ST_RD_REQ;
                                ar_valid_d = 1'b1;
                                ar_addr_d  = row_addr(addr0_q, row_q + 2'd1);
                            end
                        end
                        TYPE_PRELOADA: a_d = TILE_W'(sarray_r_data_i);
                        TYPE_TMMA: begin
                            b_d     = TILE_W'(sarray_r_data_i);
                            row_d   = 2'd0;
                            state_d = ST_COMPUTE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            ST_COMPUTE: begin
                c_d[row_q] = mac_row(a_q, b_q, row_q, (prec_q == PREC_UNSIGNED),
                                     acc_q ? c_q[row_q] : c_row_t'(0));
                if (row_q == 2'd3) begin
                    row_d   = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    row_d = row_q + 2'd1;
                end
            end

            ST_WR_REQ: begin
                if (sarray_aw_ready_i) begin
                    if (row_q == 2'd3) begin
                        aw_valid_d = 1'b0;
                        row_d      = 2'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        // next beat presented immediately, no bubble
                        row_d     = row_q + 2'd1;
                        aw_addr_d = row_addr(addr0_q, row_q + 2'd1);
                        aw_data_d = SARRAY_STORE_WIDTH'(c_q[row_q + 2'd1]);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            type_q     <= '0;
            addr0_q    <= '0;
            addr1_q    <= '0;
            prec_q     <= '0;
            acc_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            ready_q    <= 1'b1;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            aw_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            type_q     <= type_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            prec_q     <= prec_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            ready_q    <= ready_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            r_ready_q  <= r_ready_d;
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            aw_data_q  <= aw_data_d;
        end
    end

    assign issue_tinst_ready_o = ready_q;
    assign sarray_ar_valid_o   = ar_valid_q;
    assign sarray_ar_addr_o    = ar_addr_q;
    assign sarray_r_ready_o    = r_ready_q;
    assign sarray_aw_valid_o   = aw_valid_q;
    assign sarray_aw_addr_o    = aw_addr_q;
    assign sarray_aw_data_o    = aw_data_q;

endmodule

// File: tb/tb_sarray_top.sv
// Directed bench for sarray_top: memory responder plus one task per scenario.
module tb_sarray_top;

    logic         clk;
    logic         rst_n;
    logic         issue_tinst_valid_i;
    logic         issue_tinst_ready_o;
    logic [1:0]   issue_tinst_type_i;
    logic [31:0]  issue_tinst_addr0_i;
    logic [31:0]  issue_tinst_addr1_i;
    logic [1:0]   issue_tinst_precision_i;
    logic         issue_tinst_acc_i;
    logic         sarray_ar_valid_o;
    logic         sarray_ar_ready_i;
    logic [31:0]  sarray_ar_addr_o;
    logic         sarray_r_valid_i;
    logic         sarray_r_ready_o;
    logic [127:0] sarray_r_data_i;
    logic         sarray_aw_valid_o;
    logic         sarray_aw_ready_i;
    logic [31:0]  sarray_aw_addr_o;
    logic [127:0] sarray_aw_data_o;

    sarray_top dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .issue_tinst_valid_i     (issue_tinst_valid_i),
        .issue_tinst_ready_o     (issue_tinst_ready_o),
        .issue_tinst_type_i      (issue_tinst_type_i),
        .issue_tinst_addr0_i     (issue_tinst_addr0_i),
        .issue_tinst_addr1_i     (issue_tinst_addr1_i),
        .issue_tinst_precision_i (issue_tinst_precision_i),
        .issue_tinst_acc_i       (issue_tinst_acc_i),
        .sarray_ar_valid_o       (sarray_ar_valid_o),
        .sarray_ar_ready_i       (sarray_ar_ready_i),
        .sarray_ar_addr_o        (sarray_ar_addr_o),
        .sarray_r_valid_i        (sarray_r_valid_i),
        .sarray_r_ready_o        (sarray_r_ready_o),
        .sarray_r_data_i         (sarray_r_data_i),
        .sarray_aw_valid_o       (sarray_aw_valid_o),
        .sarray_aw_ready_i       (sarray_aw_ready_i),
        .sarray_aw_addr_o        (sarray_aw_addr_o),
        .sarray_aw_data_o        (sarray_aw_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    bit bp;
    logic [127:0] mem [bit [31:0]];
    logic [31:0]  ar_log[$];
    logic [31:0]  aw_addr_log[$];
    logic [127:0] aw_data_log[$];

    // Memory responder: reads return one cycle after AR; checks hold-while-waiting
    initial begin : responder
        bit           ar_hs, r_hs, aw_hs, ar_wait, aw_wait, rd_pending;
        logic [31:0]  ar_seen, aw_a_seen, rd_addr, ar_held, aw_a_held;
        logic [127:0] aw_d_seen, aw_d_held;
        ar_hs = 0; r_hs = 0; aw_hs = 0; ar_wait = 0; aw_wait = 0; rd_pending = 0;
        ar_seen = '0; aw_a_seen = '0; rd_addr = '0; ar_held = '0; aw_a_held = '0;
        aw_d_seen = '0; aw_d_held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sarray_ar_ready_i = 1'b0;
                sarray_aw_ready_i = 1'b0;
                sarray_r_valid_i  = 1'b0;
                sarray_r_data_i   = '0;
                ar_hs = 0; r_hs = 0; aw_hs = 0; ar_wait = 0; aw_wait = 0; rd_pending = 0;
            end else begin
                if (r_hs) rd_pending = 0;
                if (ar_hs) begin
                    n_checks++;
                    if (rd_pending !== 1'b0) begin
                        n_errors++;
                        $display("FAIL ar_outstanding: second AR at %h while read pending", ar_seen);
                    end
                    rd_pending = 1;
                    rd_addr    = ar_seen;
                    ar_log.push_back(ar_seen);
                end
                if (aw_hs) begin
                    aw_addr_log.push_back(aw_a_seen);
                    aw_data_log.push_back(aw_d_seen);
                end
                if (ar_wait) begin
                    n_checks++;
                    if (sarray_ar_valid_o !== 1'b1 || sarray_ar_addr_o !== ar_held) begin
                        n_errors++;
                        $display("FAIL ar_hold: valid=%b addr=%h required valid=1 addr=%h",
                                 sarray_ar_valid_o, sarray_ar_addr_o, ar_held);
                    end
                end
                if (aw_wait) begin
                    n_checks++;
                    if (sarray_aw_valid_o !== 1'b1 || sarray_aw_addr_o !== aw_a_held ||
                        sarray_aw_data_o !== aw_d_held) begin
                        n_errors++;
                        $display("FAIL aw_hold: valid=%b addr=%h data=%h required addr=%h data=%h",
                                 sarray_aw_valid_o, sarray_aw_addr_o, sarray_aw_data_o,
                                 aw_a_held, aw_d_held);
                    end
                end
                sarray_ar_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                sarray_aw_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                sarray_r_valid_i  = rd_pending;
                sarray_r_data_i   = (rd_pending && mem.exists(rd_addr)) ? mem[rd_addr] : '0;
                ar_hs     = sarray_ar_valid_o && sarray_ar_ready_i;
                ar_seen   = sarray_ar_addr_o;
                r_hs      = sarray_r_valid_i && sarray_r_ready_o;
                aw_hs     = sarray_aw_valid_o && sarray_aw_ready_i;
                aw_a_seen = sarray_aw_addr_o;
                aw_d_seen = sarray_aw_data_o;
                ar_wait   = sarray_ar_valid_o && !sarray_ar_ready_i;
                ar_held   = sarray_ar_addr_o;
                aw_wait   = sarray_aw_valid_o && !sarray_aw_ready_i;
                aw_a_held = sarray_aw_addr_o;
                aw_d_held = sarray_aw_data_o;
            end
        end
    end

    // Presents one instruction from a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [1:0] t, input logic [31:0] a0,
                         input logic [1:0] prec, input logic acc);
        int budget;
        issue_tinst_type_i      = t;
        issue_tinst_addr0_i     = a0;
        issue_tinst_addr1_i     = 32'hDEAD_BEEF;
        issue_tinst_precision_i = prec;
        issue_tinst_acc_i       = acc;
        issue_tinst_valid_i     = 1'b1;
        budget = 0;
        while (issue_tinst_ready_o !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: ready stayed %b, required 1", issue_tinst_ready_o);
        end
        @(negedge clk);
        issue_tinst_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (issue_tinst_ready_o !== 1'b1 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 500) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: ready stayed %b, required 1", issue_tinst_ready_o);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input logic [1:0] t, input logic [31:0] a0,
                       input logic [1:0] prec, input logic acc);
        issue(t, a0, prec, acc);
        wait_idle();
    endtask

    function automatic logic [127:0] row4(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic clear_logs();
        ar_log.delete();
        aw_addr_log.delete();
        aw_data_log.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (issue_tinst_ready_o !== 1'b1 || sarray_ar_valid_o !== 1'b0 ||
            sarray_aw_valid_o !== 1'b0 || sarray_r_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: ready=%b ar_v=%b aw_v=%b r_rdy=%b required 1 0 0 0",
                     issue_tinst_ready_o, sarray_ar_valid_o, sarray_aw_valid_o, sarray_r_ready_o);
        end
        n_checks++;
        if (sarray_aw_data_o !== 128'h0 || sarray_aw_addr_o !== 32'h0 || sarray_ar_addr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_data: aw_data=%h aw_addr=%h ar_addr=%h required 0",
                     sarray_aw_data_o, sarray_aw_addr_o, sarray_ar_addr_o);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (sarray_ar_valid_o !== 1'b0 || sarray_aw_valid_o !== 1'b0 ||
            issue_tinst_ready_o !== 1'b1 || ar_log.size() != 0) begin
            n_errors++;
            $display("FAIL reset_quiet: ar_v=%b aw_v=%b ready=%b ars=%0d required 0 0 1 0",
                     sarray_ar_valid_o, sarray_aw_valid_o, issue_tinst_ready_o, ar_log.size());
        end
    endtask

    task automatic test_preload_store();
        logic [127:0] exp;
        for (int r = 0; r < 4; r++) mem[32'h1000 + 32'(16*r)] = {4{32'(r + 1)}};
        clear_logs();
        issue(2'd0, 32'h1000, 2'd0, 1'b0);
        n_checks++;
        if (sarray_ar_valid_o !== 1'b1 || sarray_ar_addr_o !== 32'h1000 || issue_tinst_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL preloadc_first_ar: ar_v=%b addr=%h ready=%b required 1 00001000 0",
                     sarray_ar_valid_o, sarray_ar_addr_o, issue_tinst_ready_o);
        end
        wait_idle();
        n_checks++;
        if (ar_log.size() != 4) begin
            n_errors++;
            $display("FAIL preloadc_ar_count: got %0d required 4", ar_log.size());
        end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (ar_log.size() <= r || ar_log[r] !== 32'h1000 + 32'(16*r)) begin
                n_errors++;
                $display("FAIL preloadc_ar_addr%0d: got %h required %h", r,
                         (ar_log.size() > r) ? ar_log[r] : 32'hx, 32'h1000 + 32'(16*r));
            end
        end
        issue(2'd3, 32'h2000, 2'd0, 1'b0);
        n_checks++;
        if (sarray_aw_valid_o !== 1'b1 || sarray_aw_addr_o !== 32'h2000 ||
            sarray_aw_data_o !== {4{32'd1}}) begin
            n_errors++;
            $display("FAIL store_first_aw: aw_v=%b addr=%h data=%h required 1 00002000 row of 1",
                     sarray_aw_valid_o, sarray_aw_addr_o, sarray_aw_data_o);
        end
        wait_idle();
        for (int r = 0; r < 4; r++) begin
            exp = {4{32'(r + 1)}};
            n_checks++;
            if (aw_addr_log.size() <= r || aw_addr_log[r] !== 32'h2000 + 32'(16*r) ||
                aw_data_log[r] !== exp) begin
                n_errors++;
                $display("FAIL store_row%0d: got %h @%h required %h @%h", r,
                         (aw_data_log.size() > r) ? aw_data_log[r] : 128'hx,
                         (aw_addr_log.size() > r) ? aw_addr_log[r] : 32'hx,
                         exp, 32'h2000 + 32'(16*r));
            end
        end
    endtask

    task automatic test_identity();
        logic [127:0] a_tile, b_tile, exp;
        a_tile = '0;
        for (int i = 0; i < 4; i++) a_tile[8*(5*i) +: 8] = 8'd1;
        for (int n = 0; n < 16; n++) b_tile[8*n +: 8] = 8'(n);
        mem[32'h3000] = a_tile;
        mem[32'h3100] = b_tile;
        run(2'd1, 32'h3000, 2'd0, 1'b0);
        run(2'd2, 32'h3100, 2'd0, 1'b0);
        clear_logs();
        run(2'd3, 32'h4000, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp = row4(32'(4*i), 32'(4*i + 1), 32'(4*i + 2), 32'(4*i + 3));
            n_checks++;
            if (aw_data_log.size() <= i || aw_data_log[i] !== exp) begin
                n_errors++;
                $display("FAIL identity_row%0d: got %h required %h", i,
                         (aw_data_log.size() > i) ? aw_data_log[i] : 128'hx, exp);
            end
        end
    endtask

    task automatic test_signedness();
        logic [1:0]   precs [3];
        logic [31:0]  words [3];
        logic [127:0] exp;
        precs[0] = 2'd0; words[0] = 32'hFFFF_FFFC;
        precs[1] = 2'd1; words[1] = 32'd1020;
        precs[2] = 2'd2; words[2] = 32'hFFFF_FFFC;
        mem[32'h3200] = {16{8'hFF}};
        mem[32'h3300] = {16{8'h01}};
        run(2'd1, 32'h3200, 2'd0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            run(2'd2, 32'h3300, precs[p], 1'b0);
            clear_logs();
            run(2'd3, 32'h4100, 2'd0, 1'b0);
            exp = {4{words[p]}};
            n_checks++;
            if (aw_data_log.size() != 4 || aw_data_log[0] !== exp || aw_data_log[3] !== exp) begin
                n_errors++;
                $display("FAIL sign_prec%0d: beats=%0d row0=%h row3=%h required %h", p,
                         aw_data_log.size(), (aw_data_log.size() > 0) ? aw_data_log[0] : 128'hx,
                         (aw_data_log.size() > 3) ? aw_data_log[3] : 128'hx, exp);
            end
        end
    endtask

    task automatic test_accumulate();
        logic [31:0] words [2];
        logic        accs  [2];
        words[0] = 32'd12; accs[0] = 1'b1;
        words[1] = 32'd2;  accs[1] = 1'b0;
        for (int r = 0; r < 4; r++) mem[32'h5000 + 32'(16*r)] = {4{32'd10}};
        mem[32'h3400] = {16{8'h02}};
        run(2'd0, 32'h5000, 2'd0, 1'b0);
        run(2'd1, 32'h3000, 2'd0, 1'b0);
        for (int t = 0; t < 2; t++) begin
            run(2'd2, 32'h3400, 2'd0, accs[t]);
            clear_logs();
            run(2'd3, 32'h4200, 2'd0, 1'b0);
            for (int r = 0; r < 4; r++) begin
                n_checks++;
                if (aw_data_log.size() <= r || aw_data_log[r] !== {4{words[t]}}) begin
                    n_errors++;
                    $display("FAIL acc%0d_row%0d: got %h required %h", accs[t], r,
                             (aw_data_log.size() > r) ? aw_data_log[r] : 128'hx, {4{words[t]}});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]  addrs [4];
        logic [127:0] exp;
        addrs[0] = 32'hFFFF_FFF0; addrs[1] = 32'h0000_0000;
        addrs[2] = 32'h0000_0010; addrs[3] = 32'h0000_0020;
        for (int r = 0; r < 4; r++)
            mem[addrs[r]] = row4(32'(100*r), 32'(100*r + 1), 32'(100*r + 2), 32'(100*r + 3));
        bp = 1'b1;
        clear_logs();
        run(2'd0, 32'hFFFF_FFF0, 2'd0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (ar_log.size() <= r || ar_log[r] !== addrs[r]) begin
                n_errors++;
                $display("FAIL wrap_ar%0d: got %h required %h", r,
                         (ar_log.size() > r) ? ar_log[r] : 32'hx, addrs[r]);
            end
        end
        clear_logs();
        run(2'd3, 32'h6000, 2'd0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            exp = row4(32'(100*r), 32'(100*r + 1), 32'(100*r + 2), 32'(100*r + 3));
            n_checks++;
            if (aw_data_log.size() <= r || aw_data_log[r] !== exp ||
                aw_addr_log[r] !== 32'h6000 + 32'(16*r)) begin
                n_errors++;
                $display("FAIL bp_store_row%0d: got %h required %h", r,
                         (aw_data_log.size() > r) ? aw_data_log[r] : 128'hx, exp);
            end
        end
        bp = 1'b0;
    endtask

    task automatic test_back_to_back();
        int budget;
        clear_logs();
        issue_tinst_type_i  = 2'd3;
        issue_tinst_addr0_i = 32'h7000;
        issue_tinst_valid_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (issue_tinst_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_busy: ready=%b required 0", issue_tinst_ready_o);
        end
        budget = 0;
        while (issue_tinst_ready_o !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        issue_tinst_valid_i = 1'b0;
        n_checks++;
        if (issue_tinst_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_reaccept: ready=%b required 0", issue_tinst_ready_o);
        end
        wait_idle();
        n_checks++;
        if (aw_addr_log.size() != 8 || aw_addr_log[4] !== 32'h7000 || aw_addr_log[7] !== 32'h7030 ||
            aw_data_log[4] !== row4(32'd0, 32'd1, 32'd2, 32'd3)) begin
            n_errors++;
            $display("FAIL b2b_beats: count=%0d required 8 with second store at 00007000", aw_addr_log.size());
        end
    endtask

    task automatic test_reset_abort();
        issue(2'd0, 32'h1000, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (issue_tinst_ready_o !== 1'b1 || sarray_ar_valid_o !== 1'b0 || sarray_r_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_ctrl: ready=%b ar_v=%b r_rdy=%b required 1 0 0",
                     issue_tinst_ready_o, sarray_ar_valid_o, sarray_r_ready_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        run(2'd3, 32'h8000, 2'd0, 1'b0);
        n_checks++;
        if (aw_data_log.size() != 4 || aw_data_log[0] !== 128'h0 || aw_data_log[3] !== 128'h0) begin
            n_errors++;
            $display("FAIL abort_c_cleared: beats=%0d row0=%h required 4 beats of 0",
                     aw_data_log.size(), (aw_data_log.size() > 0) ? aw_data_log[0] : 128'hx);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bp = 1'b0;
        rst_n = 1'b0;
        issue_tinst_valid_i = 1'b0;
        issue_tinst_type_i = '0;
        issue_tinst_addr0_i = '0;
        issue_tinst_addr1_i = '0;
        issue_tinst_precision_i = '0;
        issue_tinst_acc_i = 1'b0;
        sarray_ar_ready_i = 1'b0;
        sarray_r_valid_i = 1'b0;
        sarray_r_data_i = '0;
        sarray_aw_ready_i = 1'b0;
        test_reset();
        test_preload_store();
        test_identity();
        test_signedness();
        test_accumulate();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
